// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 (x^31 + x^28 + 1) checker: self-synchronising prediction, lock FSM, bit-error counting.
// Optional receive polarity auto-correction is built when PRBS_CHK_POLARITY_EN is defined.
//
//   state  | meaning
//   HUNT   | searching for LOCK_COUNT consecutive clean checked words
//   LOCKED | link up; errored words counted per WINDOW, UNLOCK_ERRS of them drop the link
module prbs31_checker #(
   parameter int DATA_WIDTH    = 64,
   parameter int LOCK_COUNT    = 64,
   parameter int WINDOW        = 1024,
   parameter int UNLOCK_ERRS   = 16,
   parameter int ERR_CNT_WIDTH = 32
) (
   input  logic                     sys_clk_i,
   input  logic                     sys_reset_i,
   input  logic [DATA_WIDTH-1:0]    rx_data_i,
   input  logic                     rx_valid_i,
   input  logic                     err_clr_i,
   output logic                     link_up_o,
   output logic                     err_word_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
   output logic [15:0]              lock_loss_cnt_o
`ifdef PRBS_CHK_POLARITY_EN
   ,
   output logic                     rx_inverted_o
`endif
);

   localparam int PW = $clog2(DATA_WIDTH + 1);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int BW = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                   state_q, state_d;
   logic [GW-1:0]            good_q, good_d;
   logic [WW-1:0]            win_q, win_d;
   logic [BW-1:0]            bad_q, bad_d;
   logic [ERR_CNT_WIDTH-1:0] cnt_d, cnt_base;
   logic [ERR_CNT_WIDTH:0]   acc;
   logic [15:0]              loss_d, loss_base;
   logic                     err_word_d;

   logic [30:0]              hist;
   logic                     hist_valid;
   logic [DATA_WIDTH-1:0]    data;
   logic [DATA_WIDTH+30:0]   stream;
   logic [DATA_WIDTH-1:0]    mismatch;
   logic                     s1_valid;
   logic [DATA_WIDTH-1:0]    s1_mis;
   logic [PW-1:0]            pop;

`ifdef PRBS_CHK_POLARITY_EN
   logic invert, invert_d;
   assign data          = rx_data_i ^ {DATA_WIDTH{invert}};
   assign rx_inverted_o = invert;
`else
   assign data = rx_data_i;
`endif

   // Oldest history bit sits at stream[0]; word bit n sits at stream[n+31].
   assign stream = {data, hist};

   always_comb begin
      mismatch = '1;
      if (data != '0) begin
         for (int n = 0; n < DATA_WIDTH; n++) begin
            mismatch[n] = stream[n+31] ^ stream[n] ^ stream[n+3];
         end
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_reset_i) begin
         hist       <= '0;
         hist_valid <= 1'b0;
         s1_valid   <= 1'b0;
         s1_mis     <= '0;
      end else begin
         s1_valid <= rx_valid_i & hist_valid;
         if (rx_valid_i) begin
            hist       <= stream[DATA_WIDTH+30 -: 31];
            hist_valid <= 1'b1;
            s1_mis     <= mismatch;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         pop = pop + PW'(s1_mis[i]);
      end
   end

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      win_d      = win_q;
      bad_d      = bad_q;
      cnt_base   = err_clr_i ? '0 : err_cnt_o;
      cnt_d      = cnt_base;
      loss_base  = err_clr_i ? '0 : lock_loss_cnt_o;
      loss_d     = loss_base;
      err_word_d = s1_valid & (|s1_mis);
      acc        = {1'b0, cnt_base} + {{(ERR_CNT_WIDTH + 1 - PW){1'b0}}, pop};
`ifdef PRBS_CHK_POLARITY_EN
      invert_d   = invert;
`endif
      if (s1_valid) begin
         case (state_q)
            HUNT: begin
`ifdef PRBS_CHK_POLARITY_EN
               if (pop == PW'(DATA_WIDTH)) begin
                  invert_d = ~invert;
                  good_d   = '0;
               end else
`endif
               if (|s1_mis) begin
                  good_d = '0;
               end else if (good_q == GW'(LOCK_COUNT - 1)) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  win_d   = '0;
                  bad_d   = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end
            LOCKED: begin
               cnt_d = acc[ERR_CNT_WIDTH] ? '1 : acc[ERR_CNT_WIDTH-1:0];
               if (|s1_mis) begin
                  bad_d = bad_q + 1'b1;
               end
               if (win_q == WW'(WINDOW - 1)) begin
                  win_d = '0;
                  bad_d = '0;
               end else begin
                  win_d = win_q + 1'b1;
               end
               // Unlock overrides a window wrap landing on the same word.
               if ((|s1_mis) && (bad_q == BW'(UNLOCK_ERRS - 1))) begin
                  state_d = HUNT;
                  good_d  = '0;
                  win_d   = '0;
                  bad_d   = '0;
                  loss_d  = (loss_base == 16'hFFFF) ? loss_base : loss_base + 16'd1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_reset_i) begin
         state_q         <= HUNT;
         good_q          <= '0;
         win_q           <= '0;
         bad_q           <= '0;
         err_cnt_o       <= '0;
         lock_loss_cnt_o <= '0;
         err_word_o      <= 1'b0;
`ifdef PRBS_CHK_POLARITY_EN
         invert          <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         good_q          <= good_d;
         win_q           <= win_d;
         bad_q           <= bad_d;
         err_cnt_o       <= cnt_d;
         lock_loss_cnt_o <= loss_d;
         err_word_o      <= err_word_d;
`ifdef PRBS_CHK_POLARITY_EN
         invert          <= invert_d;
`endif
      end
   end

   assign link_up_o = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: a table of stream operations with hand-computed
// link/err_cnt/lock_loss/pulse expectations, plus hand-written lock-latency and reset checks.
module tb_prbs31_checker;

   logic        clk = 1'b0;
   logic        sys_reset = 1'b1;
   logic [63:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic        link_up;
   logic        err_word;
   logic [31:0] err_cnt;
   logic [15:0] loss_cnt;
`ifdef PRBS_CHK_POLARITY_EN
   logic        rx_inverted;
`endif

   prbs31_checker dut (
      .sys_clk_i       (clk),
      .sys_reset_i     (sys_reset),
      .rx_data_i       (rx_data),
      .rx_valid_i      (rx_valid),
      .err_clr_i       (err_clr),
      .link_up_o       (link_up),
      .err_word_o      (err_word),
      .err_cnt_o       (err_cnt),
      .lock_loss_cnt_o (loss_cnt)
`ifdef PRBS_CHK_POLARITY_EN
      ,
      .rx_inverted_o   (rx_inverted)
`endif
   );

   always #5 clk = ~clk;

   int pulse_total = 0;
   always @(negedge clk) if (err_word === 1'b1) pulse_total++;

   typedef enum {OP_RESET, OP_CLEAN, OP_BIT, OP_CORRUPT, OP_CORRUPT_CLR, OP_CLR, OP_ZERO, OP_GAP} op_t;
   typedef struct {
      op_t  op;
      int   n;
      int   bitpos;
      int   link;
      int   cnt;
      int   loss;
      int   pulses;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          pulse_mark = 0;
   logic [30:0] sr = 31'h1;
   vec_t        tbl [18];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] w);
      rx_data  = w;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // Reference PRBS31 source: b[n] = b[n-31] ^ b[n-28], bit 0 first.
   task automatic gen_word(output logic [63:0] w);
      logic nb;
      for (int i = 0; i < 64; i++) begin
         nb   = sr[0] ^ sr[3];
         w[i] = nb;
         sr   = {nb, sr[30:1]};
      end
   endtask

   task automatic run_op(input vec_t v, input int idx);
      logic [63:0] w;
      case (v.op)
         OP_RESET: begin
            sys_reset = 1'b1;
            tick();
            chk($sformatf("row%0d_reset_next_cycle_link", idx), int'(link_up), 0);
            sys_reset = 1'b0;
         end
         OP_CLEAN: for (int i = 0; i < v.n; i++) begin
            gen_word(w);
            send(w);
         end
         OP_BIT: begin
            gen_word(w);
            w[v.bitpos] = ~w[v.bitpos];
            send(w);
            gen_word(w);
            send(w);
         end
         OP_CORRUPT, OP_CORRUPT_CLR: begin
            for (int i = 0; i < v.n; i++) begin
               gen_word(w);
               w[0] = ~w[0];
               send(w);
            end
            if (v.op == OP_CORRUPT_CLR) begin
               err_clr = 1'b1;
               tick();
               err_clr = 1'b0;
            end
         end
         OP_CLR: begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
         end
         OP_ZERO: for (int i = 0; i < v.n; i++) send(64'h0);
         OP_GAP: for (int i = 0; i < v.n; i++) begin
            gen_word(w);
            send(w);
            tick();
         end
         default: ;
      endcase
      repeat (3) tick();
      chk($sformatf("row%0d_link_up", idx), int'(link_up), v.link);
      chk($sformatf("row%0d_err_cnt", idx), int'(err_cnt), v.cnt);
      chk($sformatf("row%0d_lock_loss", idx), int'(loss_cnt), v.loss);
      chk($sformatf("row%0d_err_word_pulses", idx), pulse_total - pulse_mark, v.pulses);
      pulse_mark = pulse_total;
   endtask

   initial begin
      logic [63:0] w;
      vec_t        rst_vec;

      // Starts freshly locked: window and bad-word counts at zero.
      tbl[0]  = '{OP_CORRUPT,     15,   0, 1, 45, 0, 15};
      tbl[1]  = '{OP_CLEAN,     1024,   0, 1, 45, 0,  0};
      tbl[2]  = '{OP_CORRUPT,     15,   0, 1, 90, 0, 15};
      tbl[3]  = '{OP_CORRUPT,      1,   0, 0, 93, 1,  1};
      tbl[4]  = '{OP_CLEAN,       63,   0, 0, 93, 1,  0};
      tbl[5]  = '{OP_CLEAN,        1,   0, 1, 93, 1,  0};
      tbl[6]  = '{OP_BIT,          1,  10, 1, 96, 1,  1};
      tbl[7]  = '{OP_BIT,          1,  50, 1, 99, 1,  2};
      tbl[8]  = '{OP_CORRUPT_CLR, 13,   0, 0,  3, 1, 13};
      tbl[9]  = '{OP_CLR,          0,   0, 0,  0, 0,  0};
      tbl[10] = '{OP_CLEAN,       64,   0, 1,  0, 0,  0};
      tbl[11] = '{OP_BIT,          1,  20, 1,  3, 0,  1};
      tbl[12] = '{OP_RESET,        0,   0, 0,  0, 0,  0};
      tbl[13] = '{OP_ZERO,       100,   0, 0,  0, 0, 99};
      tbl[14] = '{OP_RESET,        0,   0, 0,  0, 0,  0};
      tbl[15] = '{OP_GAP,         64,   0, 0,  0, 0,  0};
      tbl[16] = '{OP_GAP,          1,   0, 1,  0, 0,  0};
      tbl[17] = '{OP_BIT,          1,  63, 1,  3, 0,  2};

      rst_vec = '{OP_RESET, 0, 0, 0, 0, 0, 0};
      run_op(rst_vec, 99);
      chk("reset_err_word", int'(err_word), 0);

      // Lock latency: 64 valid words leave the link down, the 65th raises it two cycles after sampling.
      for (int i = 0; i < 64; i++) begin
         gen_word(w);
         send(w);
      end
      repeat (3) tick();
      chk("lock_after_64_words", int'(link_up), 0);
      gen_word(w);
      send(w);
      chk("lock_latency_cycle1", int'(link_up), 0);
      tick();
      chk("lock_latency_cycle2", int'(link_up), 1);
      chk("lock_err_cnt", int'(err_cnt), 0);
      tick();
      pulse_mark = pulse_total;

      for (int i = 0; i < 18; i++) run_op(tbl[i], i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side PRBS31 checker (x^31 + x^28 + 1). It is the counterpart of the PRBS generator that feeds the 10G PHY transmit path in the PRBS link test.
- Consumes parallel words from the PHY receive path (after gearbox/descrambler), checks them self-synchronously, declares link lock, and counts bit errors.
- Drives the per-lane link-up indication aggregated at top level.

Parameters:
- DATA_WIDTH, 64, received word width; must be >= 32; bit 0 is the earliest bit in time.
- LOCK_COUNT, 64, consecutive clean checked words required to declare lock.
- WINDOW, 1024, length in checked words of the loss-of-lock observation window.
- UNLOCK_ERRS, 16, errored words within one window that force loss of lock.
- ERR_CNT_WIDTH, 32, width of the bit-error counter.

Ports:
- sys_clk_i  in  1  single clock; all logic is on its rising edge.
- sys_reset_i  in  1  synchronous, active-high reset.
- rx_data_i  in  DATA_WIDTH  received word.
- rx_valid_i  in  1  rx_data_i is valid this cycle; no backpressure.
- err_clr_i  in  1  synchronous clear of err_cnt_o and lock_loss_cnt_o.
- link_up_o  out  1  checker is in the LOCKED state.
- err_word_o  out  1  one-cycle pulse for each checked word containing at least one mismatch.
- err_cnt_o  out  ERR_CNT_WIDTH  accumulated mismatched bits while LOCKED; saturates at all-ones.
- lock_loss_cnt_o  out  16  number of LOCKED->HUNT transitions; saturates at 0xFFFF.

Behaviour:
- Reset (synchronous, active-high): link_up_o=0, err_word_o=0, err_cnt_o=0, lock_loss_cnt_o=0, state=HUNT, history invalid, all counters 0.
- History: a 31-bit register holds the last 31 received bits, loaded on each rx_valid_i.
- Prediction: each bit n is predicted as b[n-31]^b[n-28], taken from the history register concatenated with the current word. The predictor is self-synchronising and needs no seeding.
- First valid word after reset only loads history. It is not checked and produces no error.
- Cycles with rx_valid_i=0 are ignored; history, counters and state all hold.
- All-zero rx_data_i is treated as an errored word with DATA_WIDTH mismatches. This is required because the zero stream trivially satisfies the recurrence; legal PRBS31 never contains 64 consecutive zeros.
- Pipeline:
  - Stage 1 registers the mismatch vector and its valid flag.
  - Stage 2 registers the popcount, err_word_o, the counter updates and the state transition.
  - Latency from an rx_data_i sample edge to err_word_o / link_up_o / err_cnt_o change is 2 cycles.
- HUNT state:
  - good_cnt increments on each clean checked word and clears on any errored word.
  - When good_cnt reaches LOCK_COUNT, go to LOCKED; link_up_o=1 from the next cycle.
  - Errors in HUNT pulse err_word_o but do not increment err_cnt_o.
- LOCKED state:
  - win_cnt counts checked words; when it reaches WINDOW-1 it wraps to 0 and clears bad_cnt.
  - bad_cnt counts errored words.
  - If an errored word makes bad_cnt reach UNLOCK_ERRS, go to HUNT, clear good_cnt, win_cnt and bad_cnt, and increment lock_loss_cnt_o.
  - If that word also closes the window, the unlock takes priority over the window wrap.
- err_cnt_o adds the popcount of each checked word while LOCKED, saturating.
- err_clr_i coincident with an accumulating word: the counter takes exactly that word's popcount (clear, then add).
- err_clr_i coincident with a loss of lock: lock_loss_cnt_o becomes 1.
- Reset mid-operation drops link_up_o the next cycle and invalidates history and the pipeline.

Optional Feature:
- Macro: PRBS_CHK_POLARITY_EN.
- Enabled:
  - An internal invert flag is XORed into received data before checking; it is reset to 0.
  - In HUNT, a checked word whose mismatch popcount equals DATA_WIDTH toggles the flag and clears good_cnt. Inverted PRBS31 yields all-ones mismatch against the uninverted prediction.
  - Adds output rx_inverted_o (1 bit) carrying the flag.
- Disabled: no flag and no rx_inverted_o port; inverted data is never locked.

Test Plan:
- Clean PRBS31 stream, rx_valid_i=1 continuously -> link_up_o rises 2 cycles after word 65 (1 history word + 64 checked); err_cnt_o=0 throughout.
- While locked, flip a single bit of one word -> err_cnt_o += 3 (the bit plus its two downstream taps, within the same or the next word) and err_word_o pulses 1-2 times; link_up_o stays 1.
- While locked, corrupt 16 words within 1024 -> link_up_o falls 2 cycles after the 16th; lock_loss_cnt_o=1; relock after 64 clean words.
- Corrupt 15 words, then send 1024 clean words, then 15 more corrupt words -> link stays up (window reset).
- All-zero input, and separately rx_valid_i toggling 1/0 on a clean stream -> zero input never locks; the gapped clean stream locks after 65 valid words.
- err_clr_i asserted on the same cycle a 3-bit-error word accumulates -> err_cnt_o=3. Reset asserted while locked -> link_up_o=0 the next cycle and all counters 0.
